// File: rtl/timer_counter_pkg.sv
// Shared state encodings and BCD digit limits for the stopwatch timer.
package timer_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_e;

    localparam logic [3:0] DIG_LIM_UNITS = 4'd9;
    localparam logic [3:0] DIG_LIM_TENS  = 4'd5;

endpackage

// File: rtl/timer_counter_bcd_digit.sv
// One BCD digit with a parameterised wrap limit; count and clear take effect on the next edge.
// Carry is combinational so a whole digit chain rolls over in a single cycle.
module bcd_digit
    import timer_counter_pkg::*;
#(
    parameter logic [3:0] LIMIT = DIG_LIM_UNITS
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       inc_i,
    input  logic       clr_i,
    output logic [3:0] q_o,
    output logic       carry_o
);

    logic [3:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = 4'd0;
        end else if (inc_i) begin
            q_d = (q_q == LIMIT) ? 4'd0 : q_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o     = q_q;
    assign carry_o = inc_i && (q_q == LIMIT);

endmodule

// File: rtl/timer_counter.sv
// MM:SS.mmm BCD stopwatch: IDLE/RUN/STOP control FSM driving a chain of seven BCD digits.
// Counts on the edge that samples a 1 ms pulse while in RUN; O_OVF pulses on the 59:59.999 increment.
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter bit OVF_STOP = 1'b0
) (
    input  logic        I_CLK,
    input  logic        I_RSTN,
    input  logic        I_EN_1MS,
    input  logic        I_START_STOP,
    input  logic        I_CLEAR,
    output logic [11:0] O_MS,
    output logic [7:0]  O_SEC,
    output logic [7:0]  O_MIN,
    output logic        O_RUNNING,
    output logic        O_OVF
);

    state_e     state_q, state_d;
    logic       running_q, running_d;
    logic       ovf_q, ovf_d;
    logic       count_en, cnt_inc, all_max, ovf_evt;

    logic [3:0] ms0, ms1, ms2, s0, s1, m0, m1;
    logic       c_ms0, c_ms1, c_ms2, c_s0, c_s1, c_m0, c_m1;

    always_ff @(posedge I_CLK or negedge I_RSTN) begin
        if (!I_RSTN) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (I_CLEAR) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (I_START_STOP) state_d = ST_RUN;
                ST_RUN: begin
                    if (I_START_STOP)              state_d = ST_STOP;
                    else if (OVF_STOP && ovf_evt)  state_d = ST_STOP;
                end
                ST_STOP: if (I_START_STOP) state_d = ST_RUN;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        all_max   = (ms2 == DIG_LIM_UNITS) && (ms1 == DIG_LIM_UNITS) && (ms0 == DIG_LIM_UNITS)
                 && (s1 == DIG_LIM_TENS)  && (s0 == DIG_LIM_UNITS)
                 && (m1 == DIG_LIM_TENS)  && (m0 == DIG_LIM_UNITS);
        count_en  = (state_q == ST_RUN) && I_EN_1MS && !I_CLEAR;
        // In hold mode the final increment is suppressed so the display freezes at 59:59.999.
        cnt_inc   = count_en && !(OVF_STOP && all_max);
        ovf_evt   = OVF_STOP ? (count_en && all_max) : c_m1;
        running_d = (state_d == ST_RUN);
        ovf_d     = ovf_evt;
    end

    bcd_digit #(.LIMIT(DIG_LIM_UNITS)) u_ms0 (
        .clk_i(I_CLK), .rst_ni(I_RSTN), .inc_i(cnt_inc), .clr_i(I_CLEAR), .q_o(ms0), .carry_o(c_ms0));
    bcd_digit #(.LIMIT(DIG_LIM_UNITS)) u_ms1 (
        .clk_i(I_CLK), .rst_ni(I_RSTN), .inc_i(c_ms0),   .clr_i(I_CLEAR), .q_o(ms1), .carry_o(c_ms1));
    bcd_digit #(.LIMIT(DIG_LIM_UNITS)) u_ms2 (
        .clk_i(I_CLK), .rst_ni(I_RSTN), .inc_i(c_ms1),   .clr_i(I_CLEAR), .q_o(ms2), .carry_o(c_ms2));
    bcd_digit #(.LIMIT(DIG_LIM_UNITS)) u_s0 (
        .clk_i(I_CLK), .rst_ni(I_RSTN), .inc_i(c_ms2),   .clr_i(I_CLEAR), .q_o(s0),  .carry_o(c_s0));
    bcd_digit #(.LIMIT(DIG_LIM_TENS))  u_s1 (
        .clk_i(I_CLK), .rst_ni(I_RSTN), .inc_i(c_s0),    .clr_i(I_CLEAR), .q_o(s1),  .carry_o(c_s1));
    bcd_digit #(.LIMIT(DIG_LIM_UNITS)) u_m0 (
        .clk_i(I_CLK), .rst_ni(I_RSTN), .inc_i(c_s1),    .clr_i(I_CLEAR), .q_o(m0),  .carry_o(c_m0));
    bcd_digit #(.LIMIT(DIG_LIM_TENS))  u_m1 (
        .clk_i(I_CLK), .rst_ni(I_RSTN), .inc_i(c_m0),    .clr_i(I_CLEAR), .q_o(m1),  .carry_o(c_m1));

    assign O_MS      = {ms2, ms1, ms0};
    assign O_SEC     = {s1, s0};
    assign O_MIN     = {m1, m0};
    assign O_RUNNING = running_q;
    assign O_OVF     = ovf_q;

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: wrap (u0) and hold (u1) overflow variants driven by shared stimulus.
module tb_timer_counter;

    localparam int MAXC = 3599999;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0, ss = 1'b0, en = 1'b0;
    logic [11:0] ms0, ms1;
    logic [7:0]  sec0, sec1, min0, min1;
    logic        run0, run1, ovf0, ovf1;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: total elapsed milliseconds plus a symbolic state (0 idle, 1 run, 2 stop).
    int mcnt [2];
    int mst  [2];
    bit movf [2];
    bit mhold[2] = '{1'b0, 1'b1};

    typedef struct {
        bit          c, s, e;
        logic [11:0] ms;
        bit          run;
    } vec_t;
    vec_t tbl[12];

    always #5 clk = ~clk;

    timer_counter #(.OVF_STOP(1'b0)) u0 (
        .I_CLK(clk), .I_RSTN(rst_n), .I_EN_1MS(en), .I_START_STOP(ss), .I_CLEAR(clr),
        .O_MS(ms0), .O_SEC(sec0), .O_MIN(min0), .O_RUNNING(run0), .O_OVF(ovf0));

    timer_counter #(.OVF_STOP(1'b1)) u1 (
        .I_CLK(clk), .I_RSTN(rst_n), .I_EN_1MS(en), .I_START_STOP(ss), .I_CLEAR(clr),
        .O_MS(ms1), .O_SEC(sec1), .O_MIN(min1), .O_RUNNING(run1), .O_OVF(ovf1));

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] bms(input int c);
        int m = c % 1000;
        return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    function automatic logic [7:0] bsec(input int c);
        int s = (c / 1000) % 60;
        return {4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [7:0] bmin(input int c);
        int m = c / 60000;
        return {4'(m / 10), 4'(m % 10)};
    endfunction

    task automatic bcd_chk(input string name, input logic [11:0] ms, input logic [7:0] sec,
                           input logic [7:0] mn);
        bit bad;
        bad = (ms[11:8] > 9) || (ms[7:4] > 9) || (ms[3:0] > 9) || (sec[7:4] > 5) ||
              (sec[3:0] > 9) || (mn[7:4] > 5) || (mn[3:0] > 9);
        n_chk++;
        if (bad) begin
            n_fail++;
            $display("FAIL %s bcd: got %h:%h.%h, required valid BCD with tens<=5", name, mn, sec, ms);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mcnt[i] = 0; mst[i] = 0; movf[i] = 1'b0;
        end
    endtask

    task automatic model_step(input bit c, input bit s, input bit e);
        bit ce;
        for (int i = 0; i < 2; i++) begin
            if (c) begin
                mcnt[i] = 0; mst[i] = 0; movf[i] = 1'b0;
            end else begin
                ce      = (mst[i] == 1) && e;
                movf[i] = ce && (mcnt[i] == MAXC);
                if (ce) mcnt[i] = (mcnt[i] == MAXC) ? (mhold[i] ? MAXC : 0) : mcnt[i] + 1;
                case (mst[i])
                    0: if (s) mst[i] = 1;
                    1: if (s || (movf[i] && mhold[i])) mst[i] = 2;
                    default: if (s) mst[i] = 1;
                endcase
            end
        end
    endtask

    task automatic check_models();
        chk("u0 ms",  ms0,  bms(mcnt[0]));
        chk("u0 sec", sec0, bsec(mcnt[0]));
        chk("u0 min", min0, bmin(mcnt[0]));
        chk("u0 run", run0, (mst[0] == 1) ? 1 : 0);
        chk("u0 ovf", ovf0, movf[0]);
        chk("u1 ms",  ms1,  bms(mcnt[1]));
        chk("u1 sec", sec1, bsec(mcnt[1]));
        chk("u1 min", min1, bmin(mcnt[1]));
        chk("u1 run", run1, (mst[1] == 1) ? 1 : 0);
        chk("u1 ovf", ovf1, movf[1]);
        bcd_chk("u0", ms0, sec0, min0);
        bcd_chk("u1", ms1, sec1, min1);
    endtask

    // Called at a negedge: drives inputs, lets one posedge sample them, checks at the next negedge.
    task automatic step(input bit c, input bit s, input bit e);
        clr = c; ss = s; en = e;
        @(posedge clk);
        model_step(c, s, e);
        @(negedge clk);
        clr = 1'b0; ss = 1'b0; en = 1'b0;
        check_models();
    endtask

    task automatic do_reset();
        clr = 1'b0; ss = 1'b0; en = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Place both counters at 59:59.998 without spending millions of cycles counting there.
    task automatic preload_near_max();
        force u0.u_ms0.q_q = 4'd8; force u0.u_ms1.q_q = 4'd9; force u0.u_ms2.q_q = 4'd9;
        force u0.u_s0.q_q  = 4'd9; force u0.u_s1.q_q  = 4'd5;
        force u0.u_m0.q_q  = 4'd9; force u0.u_m1.q_q  = 4'd5;
        force u1.u_ms0.q_q = 4'd8; force u1.u_ms1.q_q = 4'd9; force u1.u_ms2.q_q = 4'd9;
        force u1.u_s0.q_q  = 4'd9; force u1.u_s1.q_q  = 4'd5;
        force u1.u_m0.q_q  = 4'd9; force u1.u_m1.q_q  = 4'd5;
        @(posedge clk);
        @(negedge clk);
        release u0.u_ms0.q_q; release u0.u_ms1.q_q; release u0.u_ms2.q_q;
        release u0.u_s0.q_q;  release u0.u_s1.q_q;  release u0.u_m0.q_q; release u0.u_m1.q_q;
        release u1.u_ms0.q_q; release u1.u_ms1.q_q; release u1.u_ms2.q_q;
        release u1.u_s0.q_q;  release u1.u_s1.q_q;  release u1.u_m0.q_q; release u1.u_m1.q_q;
        mcnt[0] = MAXC - 1;
        mcnt[1] = MAXC - 1;
    endtask

    initial begin
        tbl[0]  = '{c:0, s:1, e:1, ms:12'h000, run:1};
        tbl[1]  = '{c:0, s:0, e:1, ms:12'h001, run:1};
        tbl[2]  = '{c:0, s:0, e:0, ms:12'h001, run:1};
        tbl[3]  = '{c:0, s:0, e:1, ms:12'h002, run:1};
        tbl[4]  = '{c:0, s:1, e:1, ms:12'h003, run:0};
        tbl[5]  = '{c:0, s:0, e:1, ms:12'h003, run:0};
        tbl[6]  = '{c:0, s:1, e:0, ms:12'h003, run:1};
        tbl[7]  = '{c:0, s:0, e:1, ms:12'h004, run:1};
        tbl[8]  = '{c:1, s:1, e:1, ms:12'h000, run:0};
        tbl[9]  = '{c:0, s:0, e:1, ms:12'h000, run:0};
        tbl[10] = '{c:0, s:1, e:0, ms:12'h000, run:1};
        tbl[11] = '{c:1, s:0, e:0, ms:12'h000, run:0};

        // Reset values while reset is held.
        model_reset();
        #1;
        chk("reset ms", ms0, 0); chk("reset sec", sec0, 0); chk("reset min", min0, 0);
        chk("reset run", run0, 0); chk("reset ovf", ovf0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].c, tbl[i].s, tbl[i].e);
            chk($sformatf("tbl[%0d] u0 ms", i), ms0, tbl[i].ms);
            chk($sformatf("tbl[%0d] u1 ms", i), ms1, tbl[i].ms);
            chk($sformatf("tbl[%0d] u0 run", i), run0, tbl[i].run);
            chk($sformatf("tbl[%0d] sec", i), sec0, 0);
        end

        // 1000 pulses make one second.
        do_reset();
        step(0, 1, 0);
        repeat (1000) step(0, 0, 1);
        chk("1s sec", sec0, 8'h01); chk("1s ms", ms0, 12'h000); chk("1s run", run0, 1);

        // Overflow: wrap for u0, hold-and-stop for u1.
        do_reset();
        step(0, 1, 0);
        preload_near_max();
        step(0, 0, 1);
        chk("pre-ovf ovf", ovf0, 0); chk("pre-ovf ms", ms0, 12'h999);
        step(0, 0, 1);
        chk("wrap ovf", ovf0, 1);   chk("wrap ms", ms0, 12'h000);
        chk("wrap sec", sec0, 8'h00); chk("wrap min", min0, 8'h00); chk("wrap run", run0, 1);
        chk("hold ovf", ovf1, 1);   chk("hold ms", ms1, 12'h999);
        chk("hold sec", sec1, 8'h59); chk("hold min", min1, 8'h59); chk("hold run", run1, 0);
        step(0, 0, 1);
        chk("ovf one-shot u0", ovf0, 0); chk("ovf one-shot u1", ovf1, 0);
        chk("post-wrap ms", ms0, 12'h001); chk("post-hold ms", ms1, 12'h999);

        // Stop coincident with a pulse counts that pulse, then holds.
        do_reset();
        step(0, 1, 0);
        repeat (5) step(0, 0, 1);
        step(0, 1, 1);
        chk("stop+en ms", ms0, 12'h006); chk("stop+en run", run0, 0);
        repeat (10) step(0, 0, 1);
        chk("stop hold ms", ms0, 12'h006);

        // Clear beats start/stop from STOP.
        do_reset();
        step(0, 1, 0);
        repeat (1234) step(0, 0, 1);
        step(0, 1, 0);
        chk("stop at 1.234 ms", ms0, 12'h234); chk("stop at 1.234 sec", sec0, 8'h01);
        step(1, 1, 0);
        chk("clr+ss ms", ms0, 0); chk("clr+ss sec", sec0, 0); chk("clr+ss run", run0, 0);
        step(0, 0, 1);
        chk("clr+ss idle ms", ms0, 0);

        // Asynchronous reset in the middle of a run.
        do_reset();
        step(0, 1, 0);
        repeat (12345) step(0, 0, 1);
        chk("12.345 ms", ms0, 12'h345); chk("12.345 sec", sec0, 8'h12);
        #2 rst_n = 1'b0;
        #1;
        chk("async ms", ms0, 0); chk("async sec", sec0, 0); chk("async min", min0, 0);
        chk("async run", run0, 0); chk("async ovf", ovf0, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(0, 0, 1);
        chk("post-reset idle run", run0, 0); chk("post-reset idle ms", ms0, 0);
        step(0, 1, 0);
        chk("post-reset start", run0, 1);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 Parameter OVF_STOP, default 0: overflow policy; 0 wraps 59:59.999 to 00:00.000 and keeps running, 1 holds 59:59.999 and enters STOP.
REQ-002 The block SHALL use one clock, I_CLK; reset is asynchronous and active-low, I_RSTN.
REQ-003 I_CLK  input  1  system clock, 16 MHz.
REQ-004 I_RSTN  input  1  asynchronous active-low reset.
REQ-005 I_EN_1MS  input  1  one-cycle pulse per millisecond from the clock divider.
REQ-006 I_START_STOP  input  1  one-cycle pulse from debounced button; toggles run/stop.
REQ-007 I_CLEAR  input  1  one-cycle pulse; zeroes count, returns to IDLE.
REQ-008 O_MS  output  12  milliseconds, 3 BCD digits [11:8]=hundreds, [7:4]=tens, [3:0]=units.
REQ-009 O_SEC  output  8  seconds, 2 BCD digits, tens 0-5.
REQ-010 O_MIN  output  8  minutes, 2 BCD digits, tens 0-5.
REQ-011 O_RUNNING  output  1  high while in state RUN.
REQ-012 O_OVF  output  1  one-cycle pulse on the 59:59.999 rollover event.

Function
REQ-013 States SHALL be IDLE, RUN and STOP, encoded in 2 bits.
REQ-014 IDLE -> RUN on I_START_STOP; RUN -> STOP on I_START_STOP; STOP -> RUN on I_START_STOP.
REQ-015 I_CLEAR in any state SHALL force IDLE and zero all digits on the next edge.
REQ-016 I_CLEAR and I_START_STOP in the same cycle: I_CLEAR wins, next state IDLE, count zero.
REQ-017 Counting occurs only when the registered state is RUN and I_EN_1MS=1; the count updates on that same edge, visible one cycle after the pulse is sampled.
REQ-018 IDLE with I_START_STOP and I_EN_1MS in the same cycle: state goes to RUN, that pulse is not counted.
REQ-019 RUN with I_START_STOP and I_EN_1MS in the same cycle: the pulse is counted and the state goes to STOP.
REQ-020 Each BCD digit SHALL increment 0..9 (tens of sec/min 0..5) and wrap to 0 with a carry into the next digit, all in one cycle.
REQ-021 Digits SHALL never hold a non-BCD value; sec/min tens SHALL never exceed 5.
REQ-022 The increment at 59:59.999: O_OVF=1 for exactly one cycle. With OVF_STOP=0 the count goes to 00:00.000 and stays in RUN. With OVF_STOP=1 the count holds 59:59.999 and goes to STOP.
REQ-023 STOP SHALL hold the count unchanged regardless of I_EN_1MS.
REQ-024 O_RUNNING SHALL be registered and equal (state==RUN).

Reset
REQ-025 I_RSTN low SHALL asynchronously force state IDLE, O_MS=0x000, O_SEC=0x00, O_MIN=0x00, O_RUNNING=0, O_OVF=0.
REQ-026 Reset release SHALL be synchronised by the existing reset path; the block needs no internal synchroniser.
REQ-027 Reset asserted mid-count SHALL discard the count; no value is retained.

Structure
REQ-028 The shared package SHALL hold the state encodings (IDLE=2'd0, RUN=2'd1, STOP=2'd2) and the digit limits (9, 5).
REQ-029 A sub-module bcd_digit SHALL hold one digit. It has a parameterised limit, inputs inc and clr, and outputs q[3:0] and carry (inc && q==limit).
REQ-030 timer_counter SHALL instantiate 7 bcd_digit instances, chained by carry, plus the FSM.

Verification
REQ-031 Reset, pulse START_STOP, apply 1000 I_EN_1MS pulses: O_SEC=0x01, O_MS=0x000, O_RUNNING=1.
REQ-032 Preload to 59:59.998 via the run, apply 2 pulses (OVF_STOP=0): O_OVF pulses once, count=00:00.000, O_RUNNING=1. Repeat with OVF_STOP=1: count holds 59:59.999, state STOP.
REQ-033 RUN at 00:00.005, START_STOP coincident with I_EN_1MS: O_MS=0x006, O_RUNNING=0; a further 10 pulses leave 0x006.
REQ-034 STOP at 00:01.234, CLEAR and START_STOP in the same cycle: count zero, IDLE, O_RUNNING=0.
REQ-035 Assert I_RSTN low asynchronously mid-RUN at 00:12.345: outputs go to zero with no clock edge; after release the block is in IDLE.
REQ-036 A bench check SHALL flag any non-BCD digit, or any sec/min tens value above 5, on every cycle.
